// File: rtl/multi_button_debouncer.sv
// N-lane push-button conditioner: two-flop synchroniser, counting debounce filter,
// registered press/release pulses and an optional hold-to-auto-repeat pulse train.
module multi_button_debouncer #(
  parameter int                N_BUTTONS     = 4,
  parameter int                CNT_WIDTH     = 16,
  parameter bit                ACTIVE_LOW    = 1'b1,
  parameter bit                REPEAT_EN     = 1'b1,
  parameter int                HOLD_W        = 24,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES   = 24'd12_500_000,
  parameter logic [HOLD_W-1:0] REPEAT_CYCLES = 24'd2_500_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] pb,
  output logic [N_BUTTONS-1:0] state,
  output logic [N_BUTTONS-1:0] down,
  output logic [N_BUTTONS-1:0] up,
  output logic [N_BUTTONS-1:0] repeat_pulse,
  output logic                 any_pressed
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);
  localparam logic [HOLD_W-1:0]    HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1'b1);
  // Terminal counts: the hold counter equals the cycle index inside the current interval
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_CYCLES - HOLD_ONE;
  localparam logic [HOLD_W-1:0]    REP_LAST  = REPEAT_CYCLES - HOLD_ONE;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    logic                 s0_r;
    logic                 s1_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_next_s;
    logic                 state_r;
    logic                 state_next_s;
    logic                 down_r;
    logic                 up_r;
    logic                 rep_s;

    // Debounce filter: count consecutive mismatch cycles, toggle on the all-ones count
    always_comb begin
      cnt_next_s   = CNT_ZERO;
      state_next_s = state_r;
      if (s1_r == state_r) begin
        cnt_next_s   = CNT_ZERO;
        state_next_s = state_r;
      end else if (cnt_r == CNT_FULL) begin
        cnt_next_s   = CNT_ZERO;
        state_next_s = ~state_r;
      end else begin
        cnt_next_s   = cnt_r + CNT_ONE;
        state_next_s = state_r;
      end
    end

    // Synchroniser, filter state and edge pulses, all registered together
    always_ff @(posedge clock) begin
      if (reset) begin
        s0_r    <= 1'b0;
        s1_r    <= 1'b0;
        cnt_r   <= CNT_ZERO;
        state_r <= 1'b0;
        down_r  <= 1'b0;
        up_r    <= 1'b0;
      end else begin
        s0_r    <= pb[i] ^ ACTIVE_LOW;
        s1_r    <= s0_r;
        cnt_r   <= cnt_next_s;
        state_r <= state_next_s;
        down_r  <= state_next_s & ~state_r;
        up_r    <= state_r & ~state_next_s;
      end
    end

    if (REPEAT_EN) begin : g_rep
      logic [HOLD_W-1:0] hold_cnt_r;
      logic [HOLD_W-1:0] hold_next_s;
      logic              first_done_r;
      logic              first_next_s;
      logic              rep_r;
      logic              rep_next_s;

      // Hold timing only advances while the level stays pressed into the next cycle
      always_comb begin
        hold_next_s  = HOLD_ZERO;
        first_next_s = 1'b0;
        rep_next_s   = 1'b0;
        if (state_r && state_next_s) begin
          if (hold_cnt_r == (first_done_r ? REP_LAST : HOLD_LAST)) begin
            hold_next_s  = HOLD_ZERO;
            first_next_s = 1'b1;
            rep_next_s   = 1'b1;
          end else begin
            hold_next_s  = hold_cnt_r + HOLD_ONE;
            first_next_s = first_done_r;
            rep_next_s   = 1'b0;
          end
        end else begin
          hold_next_s  = HOLD_ZERO;
          first_next_s = 1'b0;
          rep_next_s   = 1'b0;
        end
      end

      // Hold counter and repeat pulse register
      always_ff @(posedge clock) begin
        if (reset) begin
          hold_cnt_r   <= HOLD_ZERO;
          first_done_r <= 1'b0;
          rep_r        <= 1'b0;
        end else begin
          hold_cnt_r   <= hold_next_s;
          first_done_r <= first_next_s;
          rep_r        <= rep_next_s;
        end
      end

      assign rep_s = rep_r;
    end else begin : g_no_rep
      assign rep_s = 1'b0;
    end

    assign state[i]        = state_r;
    assign down[i]         = down_r;
    assign up[i]           = up_r;
    assign repeat_pulse[i] = rep_s;
  end

  assign any_pressed = |state;

  multi_button_debouncer_checker #(
    .N_BUTTONS(N_BUTTONS)
  ) u_checker (
    .clock        (clock),
    .reset        (reset),
    .state        (state),
    .down         (down),
    .up           (up),
    .repeat_pulse (repeat_pulse)
  );

endmodule

// Output relationship properties for the conditioner lanes.
module multi_button_debouncer_checker #(
  parameter int N_BUTTONS = 4
) (
  input logic                 clock,
  input logic                 reset,
  input logic [N_BUTTONS-1:0] state,
  input logic [N_BUTTONS-1:0] down,
  input logic [N_BUTTONS-1:0] up,
  input logic [N_BUTTONS-1:0] repeat_pulse
);

  localparam logic [N_BUTTONS-1:0] NONE = {N_BUTTONS{1'b0}};

  a_down_up_excl: assert property (@(posedge clock) disable iff (reset) (down & up) == NONE);
  a_down_pressed: assert property (@(posedge clock) disable iff (reset) (down & ~state) == NONE);
  a_up_released:  assert property (@(posedge clock) disable iff (reset) (up & state) == NONE);
  a_rep_held:     assert property (@(posedge clock) disable iff (reset) (repeat_pulse & ~state) == NONE);
  a_rep_not_down: assert property (@(posedge clock) disable iff (reset) (repeat_pulse & down) == NONE);
  a_down_edge:    assert property (@(posedge clock) disable iff (reset) down == (state & ~$past(state)));

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: phase table, directed reset/polarity sequences and
// random pin activity, all compared cycle by cycle against a window-based reference model.
module tb_multi_button_debouncer;

  localparam int HOLD = 10;
  localparam int REP  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] pb;
  logic [1:0] pb_pol;
  logic [1:0] state, down, up, rpt;
  logic       any_pressed;
  logic [1:0] p_state, p_down, p_up, p_rpt;
  logic       p_any;

  int nchecks = 0;
  int nerrors = 0;

  multi_button_debouncer #(
    .N_BUTTONS(2), .CNT_WIDTH(3), .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1),
    .HOLD_W(24), .HOLD_CYCLES(24'd10), .REPEAT_CYCLES(24'd4)
  ) dut (
    .clock(clock), .reset(reset), .pb(pb), .state(state), .down(down),
    .up(up), .repeat_pulse(rpt), .any_pressed(any_pressed)
  );

  multi_button_debouncer #(
    .N_BUTTONS(2), .CNT_WIDTH(3), .ACTIVE_LOW(1'b0), .REPEAT_EN(1'b0),
    .HOLD_W(24), .HOLD_CYCLES(24'd10), .REPEAT_CYCLES(24'd4)
  ) dut_pol (
    .clock(clock), .reset(reset), .pb(pb_pol), .state(p_state), .down(p_down),
    .up(p_up), .repeat_pulse(p_rpt), .any_pressed(p_any)
  );

  always #5 clock = ~clock;

  // Reference model, lanes 0-1 = dut, 2-3 = dut_pol. A level flips when the last
  // eight synchronised samples all disagree with it; repeats follow from the
  // number of cycles spent pressed.
  logic       m_s0 [4];
  logic       m_s1 [4];
  logic       m_st [4];
  logic       m_dn [4];
  logic       m_up [4];
  logic       m_rp [4];
  logic [7:0] m_win [4];
  int         m_n [4];

  always @(posedge clock) begin
    for (int c = 0; c < 4; c++) begin
      automatic logic [3:0] raw_v = {pb_pol, ~pb};
      automatic logic [7:0] win_v = {m_win[c][6:0], m_s1[c]};
      automatic logic       new_v = (win_v == {8{~m_st[c]}}) ? ~m_st[c] : m_st[c];
      automatic int         n_v   = (new_v && m_st[c]) ? m_n[c] + 1 : 0;
      if (reset) begin
        m_s0[c] <= 1'b0; m_s1[c] <= 1'b0; m_st[c] <= 1'b0;
        m_dn[c] <= 1'b0; m_up[c] <= 1'b0; m_rp[c] <= 1'b0;
        m_win[c] <= 8'h00; m_n[c] <= 0;
      end else begin
        m_win[c] <= win_v;
        m_s1[c]  <= m_s0[c];
        m_s0[c]  <= raw_v[c];
        m_st[c]  <= new_v;
        m_dn[c]  <= new_v & ~m_st[c];
        m_up[c]  <= m_st[c] & ~new_v;
        m_n[c]   <= n_v;
        m_rp[c]  <= (c < 2) && new_v && (n_v >= HOLD) && (((n_v - HOLD) % REP) == 0);
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    cmp("mdl_state",  32'(state),       32'({m_st[1], m_st[0]}));
    cmp("mdl_down",   32'(down),        32'({m_dn[1], m_dn[0]}));
    cmp("mdl_up",     32'(up),          32'({m_up[1], m_up[0]}));
    cmp("mdl_repeat", 32'(rpt),         32'({m_rp[1], m_rp[0]}));
    cmp("mdl_any",    32'(any_pressed), 32'(m_st[1] | m_st[0]));
    cmp("pol_state",  32'(p_state),     32'({m_st[3], m_st[2]}));
    cmp("pol_down",   32'(p_down),      32'({m_dn[3], m_dn[2]}));
    cmp("pol_up",     32'(p_up),        32'({m_up[3], m_up[2]}));
    cmp("pol_repeat", 32'(p_rpt),       32'({m_rp[3], m_rp[2]}));
    cmp("pol_any",    32'(p_any),       32'(m_st[3] | m_st[2]));
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    check_cycle();
  endtask

  typedef struct {
    logic [1:0] press;
    int         cycles;
    logic [1:0] st;
    int         d0, d1, u0, u1, r0;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [1:0] p, input int n, input logic [1:0] s,
                              input int d0, input int d1, input int u0, input int u1,
                              input int r0);
    vec_t v;
    v.press = p; v.cycles = n; v.st = s;
    v.d0 = d0; v.d1 = d1; v.u0 = u0; v.u1 = u1; v.r0 = r0;
    return v;
  endfunction

  task automatic run_phase(input logic [1:0] pv, input int n,
                           output int d0, output int d1, output int u0,
                           output int u1, output int r0);
    pb = ~pv;
    d0 = 0; d1 = 0; u0 = 0; u1 = 0; r0 = 0;
    for (int k = 0; k < n; k++) begin
      step();
      d0 += int'(down[0]); d1 += int'(down[1]);
      u0 += int'(up[0]);   u1 += int'(up[1]);
      r0 += int'(rpt[0]);
    end
  endtask

  initial begin
    int d0, d1, u0, u1, r0, lat;

    // Phase table: {pressed lanes, cycles, level at end, pulse counts in the phase}
    tbl.push_back(mk(2'b00,  5, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2'b01, 10, 2'b01, 1, 0, 0, 0, 0));
    tbl.push_back(mk(2'b01,  9, 2'b01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2'b01,  1, 2'b01, 0, 0, 0, 0, 1));
    tbl.push_back(mk(2'b01, 20, 2'b01, 0, 0, 0, 0, 5));
    tbl.push_back(mk(2'b00, 10, 2'b00, 0, 0, 1, 0, 2));
    tbl.push_back(mk(2'b00, 10, 2'b00, 0, 0, 0, 0, 0));
    for (int r = 1; r <= 7; r++) begin
      tbl.push_back(mk(2'b01, r, 2'b00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b00, 1, 2'b00, 0, 0, 0, 0, 0));
    end
    tbl.push_back(mk(2'b01, 20, 2'b01, 1, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 10, 2'b00, 0, 0, 1, 0, 2));
    tbl.push_back(mk(2'b11, 10, 2'b11, 1, 1, 0, 0, 0));
    tbl.push_back(mk(2'b10, 12, 2'b10, 0, 0, 1, 0, 0));
    tbl.push_back(mk(2'b00, 10, 2'b00, 0, 0, 0, 1, 0));

    reset = 1'b1; pb = 2'b11; pb_pol = 2'b00;
    for (int k = 0; k < 3; k++) step();
    cmp("reset_outputs", 32'({state, down, up, rpt, any_pressed}), 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      run_phase(tbl[i].press, tbl[i].cycles, d0, d1, u0, u1, r0);
      cmp($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
      cmp($sformatf("row%0d_down0", i), d0, tbl[i].d0);
      cmp($sformatf("row%0d_down1", i), d1, tbl[i].d1);
      cmp($sformatf("row%0d_up0", i), u0, tbl[i].u0);
      cmp($sformatf("row%0d_up1", i), u1, tbl[i].u1);
      cmp($sformatf("row%0d_rep0", i), r0, tbl[i].r0);
    end
    cmp("pol_idle", 32'(p_state), 32'd0);

    // Reset while a press is held: outputs clear, press is re-reported afterwards
    pb = 2'b10;
    for (int k = 0; k < 12; k++) step();
    cmp("t5_held", 32'(state), 32'd1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      cmp("t5_in_reset", 32'({state, down, up, rpt, any_pressed}), 32'd0);
    end
    reset = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      step();
      if (down[0]) lat = k;
    end
    cmp("t5_relatency", lat, 10);
    pb = 2'b11;
    for (int k = 0; k < 12; k++) step();

    // Active-high polarity instance
    pb_pol = 2'b01;
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      step();
      if (p_down[0]) lat = k;
    end
    cmp("t6_latency", lat, 10);
    cmp("t6_state", 32'(p_state), 32'd1);
    pb_pol = 2'b00;
    for (int k = 0; k < 12; k++) step();
    cmp("t6_release", 32'(p_state), 32'd0);

    // Random pin activity with occasional resets, checked against the model every cycle
    for (int t = 0; t < 1500; t++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 15) == 0) pb[b] = ~pb[b];
        if ($urandom_range(0, 15) == 0) pb_pol[b] = ~pb_pol[b];
      end
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      else if ($urandom_range(0, 1) == 0) reset = 1'b0;
      step();
    end
    reset = 1'b0; pb = 2'b11; pb_pol = 2'b00;
    for (int k = 0; k < 12; k++) step();
    cmp("final_idle", 32'({state, p_state}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
